// File: rtl/terrain_ram_arbiter_pkg.sv
// terrain_pkg: shared definitions for the terrain RAM arbiter and the terrain
// pseudo-random generators.
//   ta_state_t   - arbiter FSM states (idle, filling, one-cycle done)
//   LFSR_MASK    - Galois feedback mask of the 16-bit terrain LFSR
//   DEFAULT_SEED - seed used when a zero seed is supplied (zero locks the LFSR)
package terrain_pkg;

    typedef enum logic [1:0] {
        TA_IDLE = 2'd0,
        TA_FILL = 2'd1,
        TA_DONE = 2'd2
    } ta_state_t;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/terrain_ram_arbiter_galois_lfsr16.sv
// galois_lfsr16: combinational next-state function of the 16-bit Galois LFSR
// used for terrain patterns. Holds no state; the caller owns the register.
//   lfsr_cur  - current LFSR value
//   lfsr_next - value after one shift
module galois_lfsr16
    import terrain_pkg::*;
(
    input  logic [15:0] lfsr_cur,
    output logic [15:0] lfsr_next
);

    assign lfsr_next = (lfsr_cur >> 1) ^ (lfsr_cur[0] ? LFSR_MASK : 16'h0000);

endmodule

// File: rtl/terrain_ram_arbiter.sv
// terrain_ram_arbiter: shares the single-port 1-bit terrain RAM between the
// start-of-game fill engine (writes an LFSR pattern to every cell) and the
// video pipeline (one read per pixel clock). Video always wins; the fill
// engine writes only on cycles without a video request and retries the same
// address/bit when stalled.
//
// Ports
//   clk_in, rst_n_in      - pixel clock, asynchronous active-low reset
//   fill_start_in         - pulse requesting a full-table fill (ignored unless idle)
//   seed_in               - LFSR seed sampled with an accepted start (0 -> DEFAULT_SEED)
//   vid_req_in/addr_in    - video read request and address
//   vid_data_out          - RAM read data, passed straight through
//   vid_valid_out         - vid_req_in delayed by RAM_LATENCY cycles
//   ram_addr/din/we_out   - RAM port, combinational from state and vid_req_in
//   ram_dout_in           - RAM read data
//   fill_busy_out         - fill in progress
//   fill_done_out         - one-cycle pulse at fill completion
//   stall_count_out       - only with TERRAIN_ARB_STALL_CNT_EN defined: saturating
//                           count of fill cycles blocked by video reads
//
// Build option: define TERRAIN_ARB_STALL_CNT_EN to add stall_count_out.
module terrain_ram_arbiter
    import terrain_pkg::*;
#(
    parameter int          DEPTH        = 3600,
    parameter int          ADDR_W       = 16,
    parameter int          RAM_LATENCY  = 2,
    parameter logic [15:0] DEFAULT_SEED = terrain_pkg::DEFAULT_SEED
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              fill_start_in,
    input  logic [15:0]       seed_in,
    input  logic              vid_req_in,
    input  logic [ADDR_W-1:0] vid_addr_in,
    output logic              vid_data_out,
    output logic              vid_valid_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic              ram_din_out,
    output logic              ram_we_out,
    input  logic              ram_dout_in,
    output logic              fill_busy_out,
`ifdef TERRAIN_ARB_STALL_CNT_EN
    output logic [15:0]       stall_count_out,
`endif
    output logic              fill_done_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ta_state_t             state;
    logic [15:0]           lfsr;
    logic [15:0]           lfsr_next;
    logic [ADDR_W-1:0]     fill_addr;
    logic [RAM_LATENCY-1:0] vld_p;

    logic start_ok;
    logic grant;
    logic last_write;

    galois_lfsr16 u_lfsr (
        .lfsr_cur  (lfsr),
        .lfsr_next (lfsr_next)
    );

    assign start_ok   = (state == TA_IDLE) && fill_start_in;
    assign grant      = (state == TA_FILL) && !vid_req_in;
    assign last_write = grant && (fill_addr == LAST_ADDR);

    // Arbitration: zero-latency path to the RAM port. Forced to 0 while in
    // reset so the RAM sees no stray write and a clean address.
    always_comb begin
        ram_addr_out = '0;
        ram_din_out  = 1'b0;
        ram_we_out   = 1'b0;
        if (rst_n_in) begin
            if (grant) begin
                ram_addr_out = fill_addr;
                ram_din_out  = lfsr[0];
                ram_we_out   = 1'b1;
            end else begin
                ram_addr_out = vid_addr_in;
            end
        end
    end

    // Control FSM with registered busy/done flags.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= TA_IDLE;
            fill_busy_out <= 1'b0;
            fill_done_out <= 1'b0;
        end else begin
            case (state)
                TA_IDLE: begin
                    fill_done_out <= 1'b0;
                    if (fill_start_in) begin
                        state         <= TA_FILL;
                        fill_busy_out <= 1'b1;
                    end
                end
                TA_FILL: begin
                    if (last_write) begin
                        state         <= TA_DONE;
                        fill_busy_out <= 1'b0;
                        fill_done_out <= 1'b1;
                    end
                end
                TA_DONE: begin
                    state         <= TA_IDLE;
                    fill_done_out <= 1'b0;
                end
                default: begin
                    state         <= TA_IDLE;
                    fill_busy_out <= 1'b0;
                    fill_done_out <= 1'b0;
                end
            endcase
        end
    end

    // Fill datapath: loaded on every accepted start, so no reset is needed.
    // Advances only on a granted write; a stalled write replays the same cell.
    always_ff @(posedge clk_in) begin
        if (start_ok) begin
            lfsr      <= (seed_in == 16'h0000) ? DEFAULT_SEED : seed_in;
            fill_addr <= '0;
        end else if (grant) begin
            lfsr      <= lfsr_next;
            fill_addr <= fill_addr + ADDR_W'(1);
        end
    end

    // Read-valid pipeline matching the RAM read latency.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_p <= '0;
        end else begin
            vld_p <= (vld_p << 1) | RAM_LATENCY'(vid_req_in);
        end
    end

    assign vid_valid_out = vld_p[RAM_LATENCY-1];
    assign vid_data_out  = ram_dout_in;

`ifdef TERRAIN_ARB_STALL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stall_count_out <= 16'h0000;
        end else if (start_ok) begin
            stall_count_out <= 16'h0000;
        end else if ((state == TA_FILL) && vid_req_in) begin
            stall_count_out <= sat_inc16(stall_count_out);
        end
    end
`endif

endmodule

// File: tb/tb_terrain_ram_arbiter.sv
module tb_terrain_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fill_start;
    logic [15:0] seed;
    logic        vid_req;
    logic [15:0] vid_addr;
    logic        vid_data;
    logic        vid_valid;
    logic [15:0] ram_addr;
    logic        ram_din;
    logic        ram_we;
    logic        ram_dout;
    logic        busy;
    logic        done;
`ifdef TERRAIN_ARB_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    terrain_ram_arbiter dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .fill_start_in   (fill_start),
        .seed_in         (seed),
        .vid_req_in      (vid_req),
        .vid_addr_in     (vid_addr),
        .vid_data_out    (vid_data),
        .vid_valid_out   (vid_valid),
        .ram_addr_out    (ram_addr),
        .ram_din_out     (ram_din),
        .ram_we_out      (ram_we),
        .ram_dout_in     (ram_dout),
        .fill_busy_out   (busy),
`ifdef TERRAIN_ARB_STALL_CNT_EN
        .stall_count_out (stall_count),
`endif
        .fill_done_out   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural read-first RAM with two-cycle read latency.
    logic mem     [0:4095];
    logic ref_mem [0:4095];
    logic rd_p0 = 1'b0;
    logic rd_p1 = 1'b0;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[11:0]] <= ram_din;
        rd_p0 <= mem[ram_addr[11:0]];
        rd_p1 <= rd_p0;
    end
    assign ram_dout = rd_p1;

    typedef struct { int addr; int d; } wr_t;
    typedef struct { int at; int d; int chk; } rd_t;
    wr_t wr_q[$];
    rd_t rd_q[$];
    int  done_q[$];

    int total = 0;
    int bad = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write, a read
    // response or a done pulse.
    wr_t mw;
    rd_t mr;
    int  md;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    mw = wr_q.pop_front();
                    chk("write_addr", int'(ram_addr), mw.addr);
                    chk("write_bit", int'(ram_din), mw.d);
                end
            end
            if (vid_req && busy) begin
                chk("stall_we", int'(ram_we), 0);
                chk("stall_addr", int'(ram_addr), int'(vid_addr));
            end
            if (vid_valid) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    mr = rd_q.pop_front();
                    chk("read_latency", cyc, mr.at);
                    if (mr.chk != 0) chk("read_data", int'(vid_data), mr.d);
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_falls_with_done", int'(busy), 0);
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    md = done_q.pop_front();
                    chk("done_cycle", cyc, md);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected write stream for one fill; also records the final RAM image.
    task automatic push_fill(input logic [15:0] s);
        logic [15:0] l;
        l = (s == 16'h0000) ? 16'hACE1 : s;
        for (int a = 0; a < 3600; a++) begin
            wr_q.push_back('{a, int'(l[0])});
            ref_mem[a] = l[0];
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    task automatic issue_read(input int a, input int exp_d, input int check);
        vid_req  = 1'b1;
        vid_addr = 16'(a);
        rd_q.push_back('{cyc + 2, exp_d, check});
        tick();
        vid_req = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n0;
        int k;
        n0 = done_cnt;
        k = 0;
        while (done_cnt == n0 && k < limit) begin
            tick();
            k++;
        end
        chk("done_seen", int'(done_cnt != n0), 1);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 1'b0;
            ref_mem[i] = 1'b0;
        end
        rst_n      = 1'b0;
        fill_start = 1'b0;
        seed       = 16'h0000;
        vid_req    = 1'b0;
        vid_addr   = 16'h1234;

        // Reset state, with a non-zero video address present.
        #3;
        chk("rst_we", int'(ram_we), 0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_din", int'(ram_din), 0);
        chk("rst_valid", int'(vid_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_addr_follows_video", int'(ram_addr), 16'h1234);
        chk("idle_busy", int'(busy), 0);

        // Fill 1: seed 1, no video traffic, one ignored restart.
        seed       = 16'h0001;
        fill_start = 1'b1;
        push_fill(16'h0001);
        done_q.push_back(cyc + 3601);
        tick();
        fill_start = 1'b0;
        chk("busy_rise", int'(busy), 1);
        repeat (200) tick();
        seed       = 16'h1234;
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        wait_done(4000);
`ifdef TERRAIN_ARB_STALL_CNT_EN
        chk("stall_count_fill1", int'(stall_count), 0);
`endif
        tick();

        // Read-back of fill 1: hand-computed bits for seed 1.
        issue_read(0, 1, 1);
        issue_read(1, 0, 1);
        issue_read(2, 0, 1);
        issue_read(5, 0, 1);
        issue_read(11, 1, 1);
        issue_read(3599, int'(ref_mem[3599]), 1);
        repeat (4) tick();

        // Fill 2: seed 0 with a video read on the start cycle, then 100 stalls.
        seed       = 16'h0000;
        fill_start = 1'b1;
        vid_req    = 1'b1;
        vid_addr   = 16'd7;
        rd_q.push_back('{cyc + 2, int'(ref_mem[7]), 1});
        done_q.push_back(cyc + 3601 + 100);
        push_fill(16'h0000);
        tick();
        fill_start = 1'b0;
        vid_req    = 1'b0;
        repeat (50) tick();
        for (int i = 0; i < 100; i++) begin
            vid_req  = 1'b1;
            vid_addr = 16'(i * 7);
            rd_q.push_back('{cyc + 2, 0, 0});
            tick();
        end
        vid_req = 1'b0;
        wait_done(4000);
`ifdef TERRAIN_ARB_STALL_CNT_EN
        chk("stall_count_fill2", int'(stall_count), 100);
`endif
        tick();

        // Read-back of fill 2: hand-computed bits for seed 16'hACE1.
        issue_read(0, 1, 1);
        issue_read(1, 0, 1);
        issue_read(5, 1, 1);
        issue_read(100, int'(ref_mem[100]), 1);
        issue_read(3599, int'(ref_mem[3599]), 1);
        repeat (4) tick();

        // Fill 3 aborted by an asynchronous reset between clock edges.
        vid_addr   = 16'h0ABC;
        seed       = 16'h00FF;
        fill_start = 1'b1;
        push_fill(16'h00FF);
        tick();
        fill_start = 1'b0;
        repeat (30) tick();
        #2;
        rst_n = 1'b0;
        #1;
        wr_q.delete();
        done_q.delete();
        chk("abort_we", int'(ram_we), 0);
        chk("abort_addr", int'(ram_addr), 0);
        chk("abort_din", int'(ram_din), 0);
        chk("abort_valid", int'(vid_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
`ifdef TERRAIN_ARB_STALL_CNT_EN
        chk("abort_stall_count", int'(stall_count), 0);
`endif
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_abort_busy", int'(busy), 0);
        chk("post_abort_we", int'(ram_we), 0);
        chk("post_abort_addr", int'(ram_addr), 16'h0ABC);
        repeat (20) tick();

        chk("write_queue_drained", wr_q.size(), 0);
        chk("read_queue_drained", rd_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);
        chk("done_pulse_count", done_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
